// File: rtl/song_sequencer.sv
// song_sequencer: walks a note table in a synchronous-read ROM and drives the buzzer wave generator.
// Build option SEQ_GAP_EN: silences the last tick period of multi-tick notes for articulation.
module song_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DIV_W  = 17,
  parameter int DUR_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tempo,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DIV_W+DUR_W:0]   rom_data,
  output logic [DIV_W-1:0]       div,
  output logic                   enable,
  output logic                   volume,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        tempo_sync;  // [1:0] synchronizer, [2] edge-detect history
  logic              tick;
  logic [DUR_W-1:0]  remaining, remaining_next;
  logic [ADDR_W-1:0] rom_addr_next;
  logic [DIV_W-1:0]  div_next;
  logic              enable_next;

  logic [DIV_W-1:0]  entry_div;
  logic [DUR_W-1:0]  entry_dur;
  logic              entry_end;

  assign entry_div = rom_data[DIV_W-1:0];
  assign entry_dur = rom_data[DIV_W+DUR_W-1:DIV_W];
  assign entry_end = rom_data[DIV_W+DUR_W];
  assign tick      = tempo_sync[1] & ~tempo_sync[2];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    rom_addr_next  = rom_addr;
    div_next       = div;
    enable_next    = enable;
    remaining_next = remaining;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next    = FETCH;
          rom_addr_next = '0;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        if (entry_end) begin
          if (loop) begin
            state_next    = FETCH;
            rom_addr_next = '0;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next     = PLAY;
          div_next       = entry_div;
          enable_next    = (entry_div != '0);
          remaining_next = (entry_dur == '0) ? DUR_W'(1) : entry_dur;
        end
      end
      PLAY: begin
        if (tick) begin
          if (remaining == DUR_W'(1)) begin
            state_next    = FETCH;
            rom_addr_next = rom_addr + ADDR_W'(1);
          end else begin
            remaining_next = remaining - DUR_W'(1);
`ifdef SEQ_GAP_EN
            // Entering the final tick period of a multi-tick note: mute until the next note loads.
            if (remaining == DUR_W'(2)) enable_next = 1'b0;
`endif
          end
        end
      end
      DONE: begin
        state_next  = IDLE;
        div_next    = '0;
        enable_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over everything once playback is under way.
    if (stop && state != IDLE) begin
      state_next  = IDLE;
      div_next    = '0;
      enable_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tempo_sync <= '0;
      rom_addr   <= '0;
      div        <= '0;
      enable     <= 1'b0;
      remaining  <= '0;
      busy       <= 1'b0;
      volume     <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      tempo_sync <= {tempo_sync[1:0], tempo};
      state      <= state_next;
      rom_addr   <= rom_addr_next;
      div        <= div_next;
      enable     <= enable_next;
      remaining  <= remaining_next;
      busy       <= (state_next != IDLE);
      volume     <= (state_next != IDLE);
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed and random songs against a note-level playback model.
module tb_song_sequencer;

  localparam int AW = 7;
  localparam int DW = 17;
  localparam int UW = 6;
  localparam int EW = DW + UW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tempo = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [EW-1:0] rom_data;
  logic [DW-1:0] div;
  logic          enable, volume, busy, done;

  logic [EW-1:0] rom [2**AW];
  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;

  song_sequencer #(.ADDR_W(AW), .DIV_W(DW), .DUR_W(UW)) dut (
    .clk(clk), .rst(rst), .tempo(tempo), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .div(div), .enable(enable),
    .volume(volume), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tempo period; the synchronized tick lands well inside the high phase.
  task automatic tick_pulse();
    tempo = 1'b1;
    wait_clk(4);
    tempo = 1'b0;
    wait_clk(4);
  endtask

  function automatic logic [EW-1:0] mk(input logic e, input int dur, input int d);
    mk = {e, dur[UW-1:0], d[DW-1:0]};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 2**AW; i++) rom[i] = mk(1'b1, 0, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_div"}, div, 0);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_volume"}, volume, 0);
  endtask

  // Reference player: entries play in address order, duration 0 counts as 1, div 0 is silent,
  // an end marker either restarts (while loops remain) or finishes with one done pulse.
  // Returns early at the start of note number max_notes (0 = play to the end).
  task automatic run_song(input int loops, input int max_notes);
    int            addr  = 0;
    int            left  = loops;
    int            notes = 0;
    int            base  = done_cnt;
    int            d;
    logic [EW-1:0] e;
    logic          exp_en;
    loop  = (loops > 0);
    start = 1'b1;
    wait_clk(1);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_volume", volume, 1);
    check("start_addr", rom_addr, 0);
    wait_clk(1);
    check("load_div_hold", div, 0);
    wait_clk(1);
    for (int guard = 0; guard < 400; guard++) begin
      e = rom[addr];
      if (e[EW-1]) begin
        if (left > 0) begin
          left--;
          addr = 0;
          if (left == 0) loop = 1'b0;
          continue;
        end
        check("end_addr", rom_addr, addr);
        wait_clk(3);
        check("done_count", done_cnt, base + 1);
        check("done_low", done, 0);
        check_idle("end");
        return;
      end
      d = int'(e[DW+UW-1:DW]);
      if (d == 0) d = 1;
      notes++;
      for (int k = 1; k <= d; k++) begin
        exp_en = (e[DW-1:0] != '0);
`ifdef SEQ_GAP_EN
        if (k == d && d >= 2) exp_en = 1'b0;
`endif
        if (k == 1) check("note_addr", rom_addr, addr);
        check("note_div", div, e[DW-1:0]);
        check("note_enable", enable, exp_en);
        check("note_busy", busy, 1);
        if (k == 1 && notes == max_notes) return;
        tick_pulse();
      end
      addr = (addr + 1) % (2**AW);
    end
    check("song_bounded", busy, 0);
  endtask

  initial begin
    int base;
    int n;

    // Reset state.
    clear_rom();
    wait_clk(2);
    check("rst_addr", rom_addr, 0);
    check("rst_done", done, 0);
    check_idle("rst");
    rst = 1'b0;
    wait_clk(2);

    // Single note then end marker.
    rom[0] = mk(1'b0, 2, 1000);
    run_song(0, 0);
    wait_clk(2);

    // Rest followed by a one-tick note.
    clear_rom();
    rom[0] = mk(1'b0, 3, 0);
    rom[1] = mk(1'b0, 1, 500);
    run_song(0, 0);
    wait_clk(2);

    // Looping twice, then loop dropped so the third end marker finishes.
    clear_rom();
    rom[0] = mk(1'b0, 1, 700);
    run_song(2, 0);
    wait_clk(2);

    // Start while busy is ignored; stop aborts with no done pulse.
    clear_rom();
    rom[0] = mk(1'b0, 1, 500);
    rom[1] = mk(1'b0, 3, 900);
    base = done_cnt;
    run_song(0, 2);
    start = 1'b1;
    wait_clk(1);
    start = 1'b0;
    wait_clk(2);
    check("busy_start_addr", rom_addr, 1);
    check("busy_start_div", div, 900);
    stop = 1'b1;
    wait_clk(1);
    stop = 1'b0;
    check("stop_done", done, 0);
    check_idle("stop");
    wait_clk(20);
    check("stop_no_done", done_cnt, base);

    // Start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    wait_clk(1);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", busy, 0);
    wait_clk(3);
    check_idle("startstop");

    // Random songs, some looping.
    for (int s = 0; s < 4; s++) begin
      clear_rom();
      n = int'($urandom_range(2, 5));
      for (int i = 0; i < n; i++)
        rom[i] = mk(1'b0, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, (1 << DW) - 1)));
      rom[n] = mk(1'b1, int'($urandom_range(0, 63)), int'($urandom));
      run_song(int'($urandom_range(0, 2)), 0);
      wait_clk(2);
    end

    // Repeated pitch: articulation gap only on the multi-tick note when enabled.
    clear_rom();
    rom[0] = mk(1'b0, 4, 800);
    rom[1] = mk(1'b0, 1, 800);
    run_song(0, 0);
    wait_clk(2);

    // Table with no end marker and zero durations: address wraps, then async reset mid-note.
    for (int i = 0; i < 2**AW; i++)
      rom[i] = mk(1'b0, 0, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5000)));
    run_song(0, 2**AW + 2);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_addr", rom_addr, 0);
    check("rst_mid_done", done, 0);
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    wait_clk(2);

    // Normal playback after the mid-song reset.
    clear_rom();
    rom[0] = mk(1'b0, 2, 1234);
    run_song(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
